// File: rtl/clock_pkg.sv
// Shared constants for the cascaded modulo clock counter.
// Default geometry plus the encoding of the count direction input.
package clock_pkg;

  localparam int DEF_W = 7;
  localparam int DEF_N = 3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/clock_stage.sv
// One loadable up/down modulo counter stage with combinational wrap carry.
// Count and tick update on the edge after a step; no backpressure, carry is same-cycle.
module clock_stage
  import clock_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic         dir,
  input  logic [W-1:0] max,
  input  logic         loaden,
  input  logic [W-1:0] load,
  output logic [W-1:0] count,
  output logic         carry,
  output logic         tick
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_q, count_d;
  logic         tick_q, tick_d;

  always_comb begin
    count_d = count_q;
    carry   = 1'b0;
    if (loaden) begin
      count_d = (load > max) ? max : load;
    end else if (step) begin
      if (dir == DIR_UP) begin
        // >= rather than == so a count stranded above a lowered max still wraps
        if (count_q >= max) begin
          count_d = '0;
          carry   = 1'b1;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q == '0) begin
          count_d = max;
          carry   = 1'b1;
        end else if (count_q > max) begin
          count_d = max;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
    tick_d = carry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;

endmodule

// File: rtl/clock_chain.sv
// Cascade of N modulo counter stages with same-edge carry ripple and a rollover pulse.
// Whole chain updates on one edge, tick/rollover one cycle later; no backpressure.
module clock_chain
  import clock_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           dir,
  input  logic [N*W-1:0] res_compare,
  input  logic [N-1:0]   loaden,
  input  logic [N*W-1:0] load,
  output logic [N*W-1:0] count,
  output logic [N-1:0]   tick,
  output logic           rollover
);

  logic [N-1:0] carry_vec;
  logic         rollover_q, rollover_d;

  for (genvar i = 0; i < N; i++) begin : g_stage
    logic st;
    logic cy;

    if (i == 0) begin : g_first
      assign st = enable & ~loaden[0];
    end else begin : g_next
      // per-stage nets keep the ripple from looping through one shared vector
      assign st = g_stage[i-1].cy & ~loaden[i];
    end

    clock_stage #(.W(W)) u_stage (
      .clk    (clk),
      .reset  (reset),
      .step   (st),
      .dir    (dir),
      .max    (res_compare[i*W +: W]),
      .loaden (loaden[i]),
      .load   (load[i*W +: W]),
      .count  (count[i*W +: W]),
      .carry  (cy),
      .tick   (tick[i])
    );

    assign carry_vec[i] = cy;
  end

  always_comb begin
    rollover_d = &carry_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rollover_q <= 1'b0;
    end else begin
      rollover_q <= rollover_d;
    end
  end

  assign rollover = rollover_q;

endmodule

// File: doc/clock_chain.md
Name: clock_chain

Overview:
- Parametrised cascade of N loadable modulo counter stages (e.g. seconds/minutes/hours) with per-stage modulus and up/down counting.
- Successor to the single-stage clock counter: adds configurable width and stage count, direction control and intra-cycle carry ripple.
- Sits between the time-base prescaler (drives enable at 1 Hz) and the display/BCD conversion logic.

Parameters:
- W, 7, bit width of each stage count.
- N, 3, number of cascaded stages; stage 0 is least significant.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  advance stage 0 by one step this cycle.
- dir  in  1  1 = count up, 0 = count down; applies to all stages.
- res_compare  in  N*W  per-stage maximum value; slice [i*W +: W] is stage i's max; modulus = max+1.
- loaden  in  N  per-stage load strobe.
- load  in  N*W  per-stage load value; slice [i*W +: W] is for stage i.
- count  out  N*W  per-stage current count.
- tick  out  N  per-stage registered wrap pulse.
- rollover  out  1  registered pulse when every stage wraps in the same step.

Behaviour:
- Reset (reset=1 at rising clk): all counts 0, tick 0, rollover 0; reset overrides loaden and enable.
- Step input, stage 0: enable & ~loaden[0].
- Step input, stage i>0: carry[i-1] & ~loaden[i].
- carry[i]: combinational wrap condition of stage i in the current cycle. No pipeline delay, so the whole chain updates on the same edge.
- Up step (dir=1):
  - count >= max -> count <= 0, wrap.
  - Otherwise count <= count+1.
  - The >= comparison recovers from a runtime decrease of res_compare.
- Down step (dir=0):
  - count == 0 -> count <= max, wrap.
  - count > max -> count <= max, no wrap.
  - Otherwise count <= count-1.
- No step: count holds.
- tick[i]: 1 for exactly one cycle, the cycle after the edge where stage i wrapped; otherwise 0.
- rollover: 1 for one cycle after an edge on which all N stages wrapped.
- Load:
  - loaden[i]=1 -> count[i] <= min(load_i, max_i); tick[i] <= 0; carry[i] = 0.
  - The loading stage ignores its step input and does not propagate carry; stages above it hold.
  - Stages below a loading stage still step normally, and loading stages may be non-contiguous.
- dir may change any cycle; it takes effect on the next edge, with no internal history.
- max = 0 (modulus 1): every step is a wrap and count stays 0.
- Width rules:
  - All arithmetic is W bits with no overflow past max.
  - max = 2^W-1 gives the full binary range; +1 from all-ones is never computed because the wrap is taken first.

Decomposition:
- Shared package clock_pkg:
  - Constants for default W/N.
  - DIR_UP = 1'b1 and DIR_DOWN = 1'b0.
- Sub-module clock_stage, one per stage via generate loop.
  - Inputs: clk, reset, step, dir, max, loaden, load.
  - Outputs: count, carry (combinational), tick (registered).
- clock_chain holds only the carry wiring and the rollover AND-reduce register.

Test Plan:
- Reset: drive reset=1 mid-count with count={5,59,59} and enable=1 -> next cycle count={0,0,0}, tick=0, rollover=0.
- Up cascade: W=7, N=3, max={23,59,59}, load {23,59,58}, dir=1, enable 2 cycles.
  - Step 1: {23,59,59}.
  - Step 2: {0,0,0}.
  - tick=3'b111 and rollover=1 the following cycle, each for one cycle only.
- Down cascade: from {0,0,0}, dir=0, 1 enable -> {23,59,59}; tick=3'b111; rollover=1.
- Load priority: count={3,10,59}, enable=1, loaden=3'b010, load stage1=40.
  - Result: stage0 -> 0 with tick[0]=1; stage1 -> 40 with tick[1]=0; stage2 holds at 3.
- Load clamp: load stage0=100 with max0=59 -> count0=59.
- Runtime max change: stage0=50, set max0=30, dir=1, enable -> count0=0 with tick[0]=1.
  - Down case: stage0=50 with max0=30 -> count0=30, no tick.
